shifter: RTL and testbench
==========================

// Module: shifter
// PURPOSE
// - 16-bit barrel shifter/rotator for the datapath ALU: logical, arithmetic and rotate, left or right.
// - Shift amount is 0..15. The result is combinational (zero latency).
// - A registered copy of result and flags is provided for pipelined consumers.
// PARAMETERS
// - none; width fixed at 16 data bits, 4 amount bits (WIDTH/SHAMT_W constants live in defs)
// PORTS
// - Clocking: one clock; reset is synchronous and active-low.
// - clk      in   1   rising-edge clock (registered outputs only)
// - rst_n    in   1   synchronous active-low reset
// - in       in   16  operand
// - n        in   4   shift/rotate amount, unsigned 0..15
// - mode     in   3   operation select, defs::shift_mode_e
// - out      out  16  combinational result
// - carry    out  1   combinational: last bit shifted/rotated out
// - zero     out  1   combinational: out == 16'h0000
// - out_q    out  16  registered out
// - carry_q  out  1   registered carry
// - zero_q   out  1   registered zero
// BEHAVIOUR
// - mode[2] selects direction: 0 = right, 1 = left. mode[1:0] selects kind: 00 pass, 01 logical, 10 arithmetic, 11 rotate.
// - 000 PASS:  out = in
// - 001 LSR:   out = in >> n (zero fill)
// - 010 ASR:   out = $signed(in) >>> n (in[15] fill)
// - 011 ROR:   out = (in >> n) | (in << (16-n))
// - 100 PASS:  out = in
// - 101 LSL:   out = in << n (zero fill)
// - 110 ASL:   identical to LSL (in << n); no overflow detection
// - 111 ROL:   out = (in << n) | (in >> (16-n))
// - n == 0: out = in for every mode; carry = 0.
// - Carry, n > 0:
//   - LSR/ASR: carry = in[n-1]
//   - LSL/ASL: carry = in[16-n]
//   - ROR: carry = out[15]
//   - ROL: carry = out[0]
// - Carry in PASS modes: 0.
// - n == 15 boundary:
//   - LSR of 16'h8000 -> 16'h0001
//   - ASR of 16'h8000 -> 16'hFFFF
//   - rotates wrap without loss
// - out, carry and zero are purely combinational from in/n/mode. They settle within the same cycle; no clock involvement.
// - Registered outputs, each rising clk:
//   - if !rst_n: out_q = 0, carry_q = 0, zero_q = 1
//   - else: out_q/carry_q/zero_q take the current combinational values; latency 1 cycle
// - Reset mid-operation affects only the registered outputs; the combinational path is unaffected.
// - X or out-of-range modes cannot occur (3-bit fully decoded); no default hazard.
// STRUCTURE
// - Package defs holds:
//   - typedef enum logic [2:0] shift_mode_e: SH_PASS, SH_LSR, SH_ASR, SH_ROR, SH_PASS2, SH_LSL, SH_ASL, SH_ROL
//   - localparams WIDTH = 16, SHAMT_W = 4
// - Sub-module shift_stage: one log-shifter stage by 2**k.
//   - Inputs: data, enable, dir, fill bit, rotate flag.
//   - Instantiate 4 stages (1, 2, 4, 8).
//   - Fill bit is in[15] for ASR, else 0.
// - The top level holds mode decode, carry/zero logic and the output register.
// TESTING
// - in=16'h8001, n=4, each mode. Required out:
//   - PASS: 8001
//   - LSR: 0800
//   - ASR: F800
//   - ROR: 1800
//   - LSL/ASL: 0010
//   - ROL: 0018
// - in=16'h8001, n=1:
//   - LSR -> 16'h4000, carry=1
//   - LSL -> 16'h0002, carry=1
//   - ROR -> 16'hC000, carry=1
// - n=0, random in, all 8 modes -> out==in, carry=0. in=0 -> zero=1.
// - in=16'h8000, n=15:
//   - LSR -> 0001
//   - ASR -> FFFF
//   - ROL -> 4000
//   - LSL -> 0000, zero=1
// - Random in/n, all modes: compare against >>, >>>, <<, ror/rol reference functions; zero mismatches.
// - Hold rst_n=0 one clk -> out_q=0, carry_q=0, zero_q=1. Release -> out_q equals prior-cycle out.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the 16-bit barrel shifter/rotator.
package defs;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    // mode[2] = direction (1 = left), mode[1:0] = kind (pass/logical/arith/rotate)
    typedef enum logic [2:0] {
        SH_PASS  = 3'b000,
        SH_LSR   = 3'b001,
        SH_ASR   = 3'b010,
        SH_ROR   = 3'b011,
        SH_PASS2 = 3'b100,
        SH_LSL   = 3'b101,
        SH_ASL   = 3'b110,
        SH_ROL   = 3'b111
    } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// One stage of a logarithmic shifter: moves the word by a fixed SHIFT
// positions when enabled, left or right, with fill or wrap-around.
module shift_stage #(
    parameter int WIDTH = 16,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic             dir_left_i,
    input  logic             fill_i,
    input  logic             rotate_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] right_d;
    logic [WIDTH-1:0] left_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // Right shift: bits vacated at the top take the fill bit or wrap from the bottom
            if (gi + SHIFT < WIDTH) begin : g_right_in
                assign right_d[gi] = data_i[gi+SHIFT];
            end else begin : g_right_edge
                assign right_d[gi] = rotate_i ? data_i[gi+SHIFT-WIDTH] : fill_i;
            end
            // Left shift: vacated low bits are zero unless rotating
            if (gi >= SHIFT) begin : g_left_in
                assign left_d[gi] = data_i[gi-SHIFT];
            end else begin : g_left_edge
                assign left_d[gi] = rotate_i ? data_i[gi+WIDTH-SHIFT] : 1'b0;
            end
        end
    endgenerate

    // Select pass-through, left or right result for this stage
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            data_o = dir_left_i ? left_d : right_d;
        end
    end

endmodule

// File: rtl/shifter.sv
// 16-bit barrel shifter/rotator: combinational result/carry/zero plus a
// one-cycle registered copy for pipelined consumers.
module shifter
    import defs::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic [SHAMT_W-1:0]   n,
    input  logic [2:0]           mode,
    output logic [WIDTH-1:0]     out,
    output logic                 carry,
    output logic                 zero,
    output logic [WIDTH-1:0]     out_q,
    output logic                 carry_q,
    output logic                 zero_q
);

    shift_mode_e mode_e;
    logic        shift_en;
    logic        rotate;
    logic        dir_left;
    logic        fill_bit;

    logic [SHAMT_W:0][WIDTH-1:0] stage_data;
    logic [SHAMT_W-1:0]          right_idx;
    logic [SHAMT_W-1:0]          left_idx;
    logic [WIDTH-1:0]            out_d;
    logic                        carry_d;
    logic                        zero_d;

    assign mode_e = shift_mode_e'(mode);

    // Decode mode into stage controls; ASR is the only mode with a non-zero fill
    always_comb begin
        shift_en = 1'b1;
        rotate   = 1'b0;
        dir_left = mode[2];
        fill_bit = 1'b0;
        case (mode_e)
            SH_PASS, SH_PASS2: shift_en = 1'b0;
            SH_ASR:            fill_bit = in[WIDTH-1];
            SH_ROR, SH_ROL:    rotate   = 1'b1;
            default:           ;
        endcase
    end

    assign stage_data[0] = in;

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .SHIFT (1 << gi)
            ) u_stage (
                .data_i     (stage_data[gi]),
                .en_i       (shift_en & n[gi]),
                .dir_left_i (dir_left),
                .fill_i     (fill_bit),
                .rotate_i   (rotate),
                .data_o     (stage_data[gi+1])
            );
        end
    endgenerate

    assign out_d = stage_data[SHAMT_W];

    // Index of the last bit pushed out: n-1 going right, 16-n going left (mod 16)
    assign right_idx = n - SHAMT_W'(1);
    assign left_idx  = SHAMT_W'(0) - n;

    // Carry is the last bit shifted/rotated out; zero when nothing moves
    always_comb begin
        carry_d = 1'b0;
        if (shift_en && (n != '0)) begin
            if (rotate) begin
                carry_d = dir_left ? out_d[0] : out_d[WIDTH-1];
            end else begin
                carry_d = dir_left ? in[left_idx] : in[right_idx];
            end
        end
    end

    assign zero_d = (out_d == '0);

    assign out   = out_d;
    assign carry = carry_d;
    assign zero  = zero_d;

    // Registered copy of the combinational results; reset only touches this path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for the barrel shifter: arithmetic reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_s;
    logic [3:0]  n_s;
    logic [2:0]  mode_s;
    logic [15:0] out, out_q;
    logic        carry, zero, carry_q, zero_q;

    int n_checks = 0;
    int n_fail   = 0;

    logic        q_valid = 1'b0;
    logic [15:0] exp_out_q;
    logic        exp_carry_q, exp_zero_q;

    always #5 clk = ~clk;

    shifter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in_s),
        .n       (n_s),
        .mode    (mode_s),
        .out     (out),
        .carry   (carry),
        .zero    (zero),
        .out_q   (out_q),
        .carry_q (carry_q),
        .zero_q  (zero_q)
    );

    // Reference: {carry, out} from plain shift operators and doubled words for rotates
    function automatic logic [16:0] model(input logic [15:0] a, input logic [3:0] sh,
                                          input logic [2:0] md);
        int          s;
        logic [31:0] w;
        logic [15:0] o;
        logic        c;
        s = int'(sh);
        if (md[1:0] == 2'b00 || s == 0) return {1'b0, a};
        case (md)
            3'd1: begin o = a >> s; c = ((a >> (s - 1)) & 16'h1) != 0; end
            3'd2: begin o = $signed(a) >>> s; c = ((a >> (s - 1)) & 16'h1) != 0; end
            3'd3: begin w = {a, a} >> s; o = w[15:0]; c = o[15]; end
            3'd7: begin w = {a, a} << s; o = w[31:16]; c = o[0]; end
            default: begin w = {16'h0, a} << s; o = w[15:0]; c = w[16]; end
        endcase
        return {c, o};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (in=%h n=%0d mode=%0d)",
                     name, got, exp, in_s, n_s, mode_s);
        end
    endtask

    // Expected registered values: what the model says at each rising edge
    always @(posedge clk) begin : p_track
        logic [16:0] m;
        m = model(in_s, n_s, mode_s);
        if (!rst_n) begin
            exp_out_q = 16'h0; exp_carry_q = 1'b0; exp_zero_q = 1'b1;
        end else begin
            exp_out_q = m[15:0]; exp_carry_q = m[16]; exp_zero_q = (m[15:0] == 16'h0);
        end
        q_valid = 1'b1;
    end

    // Every cycle: combinational and registered outputs against the model
    always @(negedge clk) begin : p_cmp
        logic [16:0] m;
        m = model(in_s, n_s, mode_s);
        chk("comb_out",   out,          m[15:0]);
        chk("comb_carry", 16'(carry),   16'(m[16]));
        chk("comb_zero",  16'(zero),    16'(m[15:0] == 16'h0));
        if (q_valid) begin
            chk("reg_out",   out_q,          exp_out_q);
            chk("reg_carry", 16'(carry_q),   16'(exp_carry_q));
            chk("reg_zero",  16'(zero_q),    16'(exp_zero_q));
        end
    end

    task automatic vec(input logic [15:0] a, input logic [3:0] sh, input logic [2:0] md,
                       input logic [15:0] eo, input logic ec, input logic ez);
        @(posedge clk); #1;
        in_s = a; n_s = sh; mode_s = md;
        @(negedge clk);
        $display("vec in=%h n=%0d mode=%0d -> out=%h carry=%0b zero=%0b", a, sh, md, out, carry, zero);
        chk("lit_out",   out,         eo);
        chk("lit_carry", 16'(carry),  16'(ec));
        chk("lit_zero",  16'(zero),   16'(ez));
    endtask

    initial begin
        logic [15:0] r;
        rst_n = 1'b0; in_s = 16'h1234; n_s = 4'd3; mode_s = 3'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("reset out_q=%h carry_q=%0b zero_q=%0b", out_q, carry_q, zero_q);
        chk("rst_out_q",   out_q,         16'h0000);
        chk("rst_carry_q", 16'(carry_q),  16'h0);
        chk("rst_zero_q",  16'(zero_q),   16'h1);
        @(posedge clk); #1 rst_n = 1'b1;

        // in=8001, n=4, every mode
        vec(16'h8001, 4'd4, 3'd0, 16'h8001, 1'b0, 1'b0);
        vec(16'h8001, 4'd4, 3'd1, 16'h0800, 1'b0, 1'b0);
        vec(16'h8001, 4'd4, 3'd2, 16'hF800, 1'b0, 1'b0);
        vec(16'h8001, 4'd4, 3'd3, 16'h1800, 1'b0, 1'b0);
        vec(16'h8001, 4'd4, 3'd4, 16'h8001, 1'b0, 1'b0);
        vec(16'h8001, 4'd4, 3'd5, 16'h0010, 1'b0, 1'b0);
        vec(16'h8001, 4'd4, 3'd6, 16'h0010, 1'b0, 1'b0);
        vec(16'h8001, 4'd4, 3'd7, 16'h0018, 1'b0, 1'b0);
        // n=1 carries
        vec(16'h8001, 4'd1, 3'd1, 16'h4000, 1'b1, 1'b0);
        vec(16'h8001, 4'd1, 3'd5, 16'h0002, 1'b1, 1'b0);
        vec(16'h8001, 4'd1, 3'd3, 16'hC000, 1'b1, 1'b0);
        // n=0: identity in all modes, carry 0
        r = 16'h5AC3;
        for (int m = 0; m < 8; m++) vec(r, 4'd0, 3'(m), r, 1'b0, 1'b0);
        vec(16'h0000, 4'd0, 3'd3, 16'h0000, 1'b0, 1'b1);
        // n=15 boundary
        vec(16'h8000, 4'd15, 3'd1, 16'h0001, 1'b0, 1'b0);
        vec(16'h8000, 4'd15, 3'd2, 16'hFFFF, 1'b0, 1'b0);
        vec(16'h8000, 4'd15, 3'd7, 16'h4000, 1'b0, 1'b0);
        vec(16'h8000, 4'd15, 3'd5, 16'h0000, 1'b0, 1'b1);

        // Random sweep checked by the model every cycle, with a reset pulse midway
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            in_s = 16'($urandom); n_s = 4'($urandom_range(0, 15)); mode_s = 3'($urandom_range(0, 7));
            $display("rnd in=%h n=%0d mode=%0d", in_s, n_s, mode_s);
            if (i == 100) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                $display("midreset out_q=%h carry_q=%0b zero_q=%0b", out_q, carry_q, zero_q);
                chk("mid_rst_out_q",  out_q,        16'h0000);
                chk("mid_rst_zero_q", 16'(zero_q),  16'h1);
                #1 rst_n = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
